// File: rtl/amc13_tts_serializer.sv
// TTS serializer: debounces the requested TTS code and streams 16-bit framed
// state words (sync, state, sequence, parity) MSB first at the AMC13 40 MHz clock.
module amc13_tts_serializer #(
  parameter int STABLE_CYCLES  = 4,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic       amc13_clk_40,
  input  logic       reset,
  input  logic [3:0] tts_state,
  output logic       tts_serial_out,
  output logic       frame_start,
  output logic [3:0] tts_sent,
  output logic       holdoff
);

  localparam logic [3:0] TTS_READY = 4'h8;
  localparam logic [3:0] TTS_BUSY  = 4'h4;
  localparam logic [3:0] TTS_OOS   = 4'h2;
  localparam logic [3:0] TTS_WARN  = 4'h1;
  localparam logic [3:0] TTS_ERROR = 4'hC;
  localparam logic [7:0] SYNC_WORD = 8'hB8;

  localparam logic [0:0] ST_HOLDOFF = 1'b0;
  localparam logic [0:0] ST_SEND    = 1'b1;

  localparam int         HOLD_W       = (HOLDOFF_FRAMES < 1) ? 1 : $clog2(HOLDOFF_FRAMES + 1);
  localparam logic [3:0] STABLE_LIMIT = 4'(STABLE_CYCLES);

  function automatic logic [3:0] sanitise(input logic [3:0] code);
    case (code)
      TTS_READY, TTS_BUSY, TTS_OOS, TTS_WARN, TTS_ERROR: sanitise = code;
      default:                                           sanitise = TTS_ERROR;
    endcase
  endfunction

  // Even parity: bit 0 makes the number of ones in bits [7:0] even.
  function automatic logic [15:0] build_frame(input logic [3:0] st, input logic [2:0] sq);
    build_frame = {SYNC_WORD, st, sq, ^{st, sq}};
  endfunction

  logic [3:0]        sample_clean;
  logic [3:0]        last_sample_reg;
  logic [3:0]        stable_cnt_reg;
  logic [3:0]        stable_cnt_next;
  logic [3:0]        filtered_reg;
  logic [3:0]        filtered_next;

  logic [3:0]        bit_cnt_reg;
  logic [15:0]       frame_reg;
  logic [15:0]       frame_capture;
  logic [2:0]        seq_reg;
  logic [0:0]        state_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              boundary;
  logic              send_zero;

  always_comb begin
    sample_clean = sanitise(tts_state);
    if (stable_cnt_reg == 4'd0 || sample_clean != last_sample_reg)
      stable_cnt_next = 4'd1;
    else if (stable_cnt_reg >= STABLE_LIMIT)
      stable_cnt_next = stable_cnt_reg;
    else
      stable_cnt_next = stable_cnt_reg + 4'd1;
    filtered_next = filtered_reg;
    if (stable_cnt_next >= STABLE_LIMIT)
      filtered_next = sample_clean;
  end

  // bit_cnt_reg is the frame position presented on the next edge; 0 means bit 15.
  assign boundary      = (bit_cnt_reg == 4'd0);
  assign send_zero     = (state_reg == ST_HOLDOFF) && (hold_cnt_reg < HOLD_W'(HOLDOFF_FRAMES));
  assign frame_capture = send_zero ? 16'h0000 : build_frame(filtered_next, seq_reg);
  assign holdoff       = (state_reg == ST_HOLDOFF);

  always_ff @(posedge amc13_clk_40 or posedge reset) begin
    if (reset) begin
      last_sample_reg <= TTS_ERROR;
      stable_cnt_reg  <= 4'd0;
      filtered_reg    <= TTS_ERROR;
      bit_cnt_reg     <= 4'd0;
      frame_reg       <= 16'h0000;
      seq_reg         <= 3'd0;
      state_reg       <= ST_HOLDOFF;
      hold_cnt_reg    <= '0;
      tts_serial_out  <= 1'b0;
      frame_start     <= 1'b0;
      tts_sent        <= TTS_ERROR;
    end else begin
      last_sample_reg <= sample_clean;
      stable_cnt_reg  <= stable_cnt_next;
      filtered_reg    <= filtered_next;
      bit_cnt_reg     <= bit_cnt_reg + 4'd1;
      if (boundary) begin
        frame_start    <= 1'b1;
        frame_reg      <= frame_capture;
        tts_serial_out <= frame_capture[15];
        if (send_zero) begin
          hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          tts_sent     <= TTS_ERROR;
        end else begin
          state_reg <= ST_SEND;
          tts_sent  <= filtered_next;
          seq_reg   <= seq_reg + 3'd1;
        end
      end else begin
        frame_start    <= 1'b0;
        tts_serial_out <= frame_reg[4'd15 - bit_cnt_reg];
      end
    end
  end

endmodule

// File: tb/tb_amc13_tts_serializer.sv
// Bench for amc13_tts_serializer: a bench-side model queues expected frames as
// stimulus is applied; received serial frames are popped and compared.
`timescale 1ns/1ps
module tb_amc13_tts_serializer;

  localparam int STABLE = 4;
  localparam int HOLDF  = 2;

  logic       amc13_clk_40 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] tts_state = 4'h8;
  logic       tts_serial_out;
  logic       frame_start;
  logic [3:0] tts_sent;
  logic       holdoff;

  amc13_tts_serializer #(.STABLE_CYCLES(STABLE), .HOLDOFF_FRAMES(HOLDF)) dut (
    .amc13_clk_40  (amc13_clk_40),
    .reset         (reset),
    .tts_state     (tts_state),
    .tts_serial_out(tts_serial_out),
    .frame_start   (frame_start),
    .tts_sent      (tts_sent),
    .holdoff       (holdoff)
  );

  always #12.5 amc13_clk_40 = ~amc13_clk_40;

  typedef struct packed {
    logic [15:0] frame;
    logic [3:0]  sent;
    logic        hold;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] hist_q[$];
  logic [3:0] filt_m;
  logic [2:0] seq_m;
  int         edge_m;
  int         tests = 0;
  int         fails = 0;
  int         rx_pos;
  logic [15:0] rx_frame;
  logic [3:0]  rx_sent;
  logic        rx_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [3:0] clean_m(input logic [3:0] code);
    return (code inside {4'h8, 4'h4, 4'h2, 4'h1, 4'hC}) ? code : 4'hC;
  endfunction

  task automatic model_reset();
    hist_q.delete();
    exp_q.delete();
    filt_m = 4'hC;
    seq_m  = 3'd0;
    edge_m = 0;
    rx_pos = -1;
  endtask

  task automatic sample_out();
    exp_t e;
    check("frame_start", frame_start, ((edge_m - 1) % 16) == 0);
    check("holdoff_lvl", holdoff, ((edge_m - 1) / 16) < HOLDF);
    if (frame_start) begin
      rx_pos   = 0;
      rx_frame = {15'h0, tts_serial_out};
      rx_sent  = tts_sent;
      rx_hold  = holdoff;
    end else if (rx_pos >= 0) begin
      rx_pos++;
      rx_frame = {rx_frame[14:0], tts_serial_out};
    end
    if (rx_pos == 15) begin
      if (exp_q.size() == 0) begin
        check("queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("frame", rx_frame, e.frame);
        check("tts_sent", rx_sent, e.sent);
        check("holdoff", rx_hold, e.hold);
        $display("[TB] frame %04h sent=%0h holdoff=%0b (expected %04h)", rx_frame, rx_sent, rx_hold, e.frame);
      end
      rx_pos = -1;
    end
  endtask

  // Called just after a rising edge; drives the input for the next edge.
  task automatic step(input logic [3:0] st);
    exp_t e;
    logic same;
    logic par;
    tts_state = st;
    edge_m++;
    hist_q.push_back(clean_m(st));
    if (hist_q.size() > STABLE) void'(hist_q.pop_front());
    if (hist_q.size() == STABLE) begin
      same = 1'b1;
      foreach (hist_q[i]) if (hist_q[i] != hist_q[0]) same = 1'b0;
      if (same) filt_m = hist_q[0];
    end
    if (((edge_m - 1) % 16) == 0) begin
      if (((edge_m - 1) / 16) < HOLDF) begin
        e.frame = 16'h0000;
        e.sent  = 4'hC;
        e.hold  = 1'b1;
      end else begin
        par     = ($countones({filt_m, seq_m}) % 2) != 0;
        e.frame = {8'hB8, filt_m, seq_m, par};
        e.sent  = filt_m;
        e.hold  = 1'b0;
        seq_m   = seq_m + 3'd1;
      end
      exp_q.push_back(e);
    end
    @(posedge amc13_clk_40);
    #1;
    sample_out();
  endtask

  task automatic hold_state(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) step(st);
  endtask

  task automatic align(input int pos);
    for (int i = 0; i < 40 && rx_pos != pos; i++) step(tts_state);
    check("align", rx_pos, pos);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_serial"}, tts_serial_out, 1'b0);
    check({tag, "_fstart"}, frame_start, 1'b0);
    check({tag, "_sent"}, tts_sent, 4'hC);
    check({tag, "_holdoff"}, holdoff, 1'b1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes [5];
    model_reset();
    repeat (3) @(posedge amc13_clk_40);
    #1;
    check_reset_outputs("rst_init");

    // Release just after an edge so the next edge is the first frame edge.
    reset = 1'b0;
    hold_state(4'h8, 42 * 16);

    // Short BUSY glitch must be filtered out.
    hold_state(4'h4, 3);
    hold_state(4'h8, 40);

    // Change mid-frame: frame in flight keeps READY, next carries BUSY.
    align(5);
    hold_state(4'h4, 40);
    hold_state(4'h8, 20);

    // Illegal codes all become ERROR.
    hold_state(4'h0, 20);
    hold_state(4'hF, 20);
    hold_state(4'h6, 20);
    hold_state(4'h2, 40);
    hold_state(4'h1, 40);

    // Random codes with random hold lengths around the filter threshold.
    codes[0] = 4'h8; codes[1] = 4'h4; codes[2] = 4'h2; codes[3] = 4'h1; codes[4] = 4'hC;
    for (int k = 0; k < 40; k++)
      hold_state(codes[$urandom_range(4, 0)], $urandom_range(8, 1));
    hold_state(4'h8, 20);

    // Asynchronous reset in the middle of a SEND frame.
    align(10);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    model_reset();
    repeat (2) @(posedge amc13_clk_40);
    #1;
    check_reset_outputs("rst_hold");
    reset = 1'b0;
    hold_state(4'h8, 6 * 16);

    check("drain", exp_q.size() <= 1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/amc13_tts_serializer.md
AMC13_TTS_SERIALIZER -- requirements
Module: amc13_tts_serializer

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive identical tts_state samples required before a new state is accepted (legal range 1-15).
REQ-002 Parameter HOLDOFF_FRAMES, default 2, number of all-zero frames sent after reset release.
REQ-003 amc13_clk_40  input  1  40 MHz experimental clock (extracted AMC13 clock); the only clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tts_state  input  4  requested TTS code, already synchronous to amc13_clk_40.
REQ-006 tts_serial_out  output  1  serial TTS bit stream, registered, drives the differential TTS output buffer.
REQ-007 frame_start  output  1  high for one cycle while tts_serial_out carries frame bit 15.
REQ-008 tts_sent  output  4  state code carried by the frame currently being transmitted.
REQ-009 holdoff  output  1  high while in HOLDOFF state.

Function
REQ-010 Frame = 16 bits, sent MSB first, one bit per amc13_clk_40 cycle: [15:8]=8'hB8 sync, [7:4]=state, [3:1]=seq, [0]=even parity over bits [7:1].
REQ-011 seq = 3-bit frame counter; increments by 1 per transmitted SEND frame; wraps 7->0; reset value 0; holdoff frames do not advance it.
REQ-012 Code sanitising: 4'h8 READY, 4'h4 BUSY, 4'h2 OOS, 4'h1 WARN, 4'hC ERROR pass through unchanged; every other code, including 4'h0 and 4'hF, maps to 4'hC.
REQ-013 Filter: sanitised tts_state sampled each cycle; a stability counter counts consecutive identical samples; a change resets the count to 1.
REQ-014 The filtered state updates to the sample once the count reaches STABLE_CYCLES; the count saturates at STABLE_CYCLES.
REQ-015 The filtered state is captured into the frame only at frame boundaries; the capture occurs in the cycle whose next edge presents bit 15. A mid-frame change never alters the frame in flight.
REQ-016 Simultaneous events: if the filter update and the frame capture occur on the same edge, the newly filtered value is used.
REQ-017 State machine HOLDOFF -> SEND: HOLDOFF outputs 0 for HOLDOFF_FRAMES x 16 cycles with frame_start still pulsing every 16 cycles, then enters SEND at a frame boundary; SEND persists until reset.
REQ-018 Bit counter 0..15 wraps 15->0 continuously in both states; frame_start asserts exactly every 16 cycles.
REQ-019 tts_sent updates on the same edge as frame_start rises; it holds 4'hC during HOLDOFF.
REQ-020 Filtered state initialises to 4'hC (ERROR) at reset; the upstream state must be stable for STABLE_CYCLES cycles before READY can be sent.

Reset
REQ-021 Reset asserted: all outputs take their reset values immediately, without waiting for a clock edge: tts_serial_out=0, frame_start=0, tts_sent=4'hC, holdoff=1. Bit counter=0, seq=0, stability count=0.
REQ-022 First frame_start is on the first rising edge after reset deasserts; reset mid-frame aborts the frame with no partial completion.

Verification
REQ-023 Reset release, tts_state=4'h8 held -> 32 zero bits with holdoff=1 and frame_start at cycles 0 and 16; cycle 32 frame = 16'hB8_8_0 plus parity (16'hB881).
REQ-024 READY held 40 frames -> seq fields run 0..7,0..; every frame has sync 8'hB8; parity bit is correct each time.
REQ-025 tts_state=4'h4 for 3 cycles then back to 4'h8 (STABLE_CYCLES=4) -> no BUSY frame is ever sent.
REQ-026 tts_state 8->4 at frame bit 10 -> the current frame still carries 8; the next frame carries 4 with tts_sent=4'h4.
REQ-027 tts_state=4'h0, then 4'hF, then 4'h6, each held 20 cycles -> the transmitted state field is always 4'hC.
REQ-028 Reset pulsed at frame bit 5 during SEND -> outputs go to reset values asynchronously, then the HOLDOFF sequence restarts and seq=0.
